// File: rtl/axi_cmd_wrr_arbiter.sv
// Weighted round-robin arbiter for one AXI command channel, with per-port outstanding-transaction limits.
// Define AXI_WRR_ARB_STARVE_EN to add per-port wait counters that force a grant after P_STARVE cycles.
module axi_cmd_wrr_arbiter #(
  parameter int unsigned P_NPORTS  = 4,
  parameter int unsigned P_IDXW    = 2,
  parameter int unsigned P_WEIGHTW = 4,
  parameter int unsigned P_OSTW    = 3,
  parameter int unsigned P_STARVE  = 64
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [P_NPORTS-1:0]           req,
  input  logic                          ack,
  input  logic [P_NPORTS-1:0]           done,
  input  logic [P_NPORTS*P_WEIGHTW-1:0] weight,
  input  logic [P_NPORTS*P_OSTW-1:0]    ost_limit,
  output logic [P_NPORTS-1:0]           gnt,
  output logic [P_IDXW-1:0]             gnt_id,
  output logic                          gnt_valid,
  output logic [P_NPORTS*P_OSTW-1:0]    ost_cnt
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e               state_q;
  logic [P_NPORTS-1:0]  gnt_q;
  logic [P_IDXW-1:0]    gnt_id_q;
  logic                 gnt_valid_q;
  logic [P_IDXW-1:0]    ptr_q;
  logic [P_WEIGHTW-1:0] credit_q;
  logic [P_OSTW-1:0]    ost_q [P_NPORTS];
  logic [P_OSTW-1:0]    ost_d [P_NPORTS];

  logic [P_WEIGHTW-1:0] weight_a [P_NPORTS];
  logic [P_OSTW-1:0]    limit_a  [P_NPORTS];
  logic [P_NPORTS-1:0]  inc;
  logic [P_NPORTS-1:0]  elig;
  logic [P_NPORTS-1:0]  starved;
  logic [P_IDXW-1:0]    base;
  logic [P_IDXW-1:0]    idx;
  logic [P_IDXW-1:0]    win;
  logic                 found;
  logic [P_NPORTS-1:0]  win_oh;
  logic [P_WEIGHTW-1:0] credit_load;
  logic                 advance;
  logic                 turn_end;

  // Eligibility uses the post-update counts so a limit hit by this ack is seen at this edge.
  always_comb begin
    for (int unsigned i = 0; i < P_NPORTS; i++) begin
      weight_a[i] = weight[i*P_WEIGHTW +: P_WEIGHTW];
      limit_a[i]  = ost_limit[i*P_OSTW +: P_OSTW];
      inc[i]      = gnt_valid_q && ack && (gnt_id_q == P_IDXW'(i));
      ost_d[i]    = ost_q[i];
      if (inc[i] && !done[i]) begin
        if (ost_q[i] != '1) ost_d[i] = ost_q[i] + 1'b1;
      end else if (!inc[i] && done[i] && (ost_q[i] != '0)) begin
        ost_d[i] = ost_q[i] - 1'b1;
      end
      elig[i] = req[i] && (ost_d[i] != '1) &&
                ((limit_a[i] == '0) || (ost_d[i] < limit_a[i]));
      ost_cnt[i*P_OSTW +: P_OSTW] = ost_q[i];
    end
  end

`ifdef AXI_WRR_ARB_STARVE_EN
  localparam int unsigned SW = $clog2(P_STARVE + 1);
  logic [SW-1:0] wait_q [P_NPORTS];

  always_comb begin
    for (int unsigned i = 0; i < P_NPORTS; i++) begin
      starved[i] = (wait_q[i] == SW'(P_STARVE));
    end
  end

  always_ff @(posedge aclk) begin
    for (int unsigned i = 0; i < P_NPORTS; i++) begin
      if (!aresetn) begin
        wait_q[i] <= '0;
      end else if (gnt_valid_q && (gnt_id_q == P_IDXW'(i))) begin
        wait_q[i] <= '0;
      end else if (req[i] && !starved[i]) begin
        wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end
`else
  assign starved = '0;
`endif

  always_comb begin
    base  = (state_q == S_GRANT) ? gnt_id_q : ptr_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    // Descending scan so the lowest-index starved port is the one left in win.
    for (int unsigned i = P_NPORTS; i > 0; i--) begin
      if (starved[i-1] && elig[i-1]) begin
        found = 1'b1;
        win   = P_IDXW'(i - 1);
      end
    end
    for (int unsigned k = 1; k <= P_NPORTS; k++) begin
      idx = P_IDXW'((32'(base) + k) % P_NPORTS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
    credit_load = (weight_a[win] == '0) ? P_WEIGHTW'(1) : weight_a[win];
    advance     = ack || !req[gnt_id_q];
    turn_end    = !req[gnt_id_q] ||
                  (credit_q == P_WEIGHTW'(1)) ||
                  !elig[gnt_id_q] ||
                  (|(starved & elig & ~gnt_q));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= P_IDXW'(P_NPORTS - 1);
      credit_q    <= '0;
      for (int unsigned i = 0; i < P_NPORTS; i++) ost_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < P_NPORTS; i++) ost_q[i] <= ost_d[i];
      if (state_q == S_IDLE) begin
        if (found) begin
          state_q     <= S_GRANT;
          gnt_q       <= win_oh;
          gnt_id_q    <= win;
          gnt_valid_q <= 1'b1;
          credit_q    <= credit_load;
        end
      end else if (advance) begin
        if (turn_end) begin
          ptr_q <= gnt_id_q;
          if (found) begin
            gnt_q       <= win_oh;
            gnt_id_q    <= win;
            gnt_valid_q <= 1'b1;
            credit_q    <= credit_load;
          end else begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
          end
        end else begin
          credit_q <= credit_q - 1'b1;
        end
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_axi_cmd_wrr_arbiter.sv
// Directed bench for axi_cmd_wrr_arbiter: vector table for rotation/hold, hand sequences for limits and corners.
module tb_axi_cmd_wrr_arbiter;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  req;
  logic        ack;
  logic [3:0]  done;
  logic [15:0] weight;
  logic [11:0] ost_limit;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_valid;
  logic [11:0] ost_cnt;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0]  req;
    logic        ack;
    logic [3:0]  done;
    logic [1:0]  id;
    logic        valid;
    logic [11:0] ost;
  } vec_t;

  vec_t tbl [22];
  int   wrr_ids [12];

  axi_cmd_wrr_arbiter #(
    .P_NPORTS (4),
    .P_IDXW   (2),
    .P_WEIGHTW(4),
    .P_OSTW   (3),
    .P_STARVE (8)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req      (req),
    .ack      (ack),
    .done     (done),
    .weight   (weight),
    .ost_limit(ost_limit),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .ost_cnt  (ost_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ev, input logic [11:0] eo);
    chk({name, ".gnt"}, 32'(gnt), 32'(eg));
    chk({name, ".gnt_id"}, 32'(gnt_id), 32'(eid));
    chk({name, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
    chk({name, ".ost_cnt"}, 32'(ost_cnt), 32'(eo));
  endtask

  initial begin
    int  acks_p0;
    int  at_cyc;
    bit  seen;

    n_cmp = 0;
    n_bad = 0;

    // WRR rotation with weights 1,2,3,4, then 10 cycles of held grant on p1.
    wrr_ids = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 0, 1, 1};
    for (int i = 0; i < 12; i++) begin
      tbl[i] = '{req: 4'hF, ack: 1'b1, done: 4'hF, id: 2'(wrr_ids[i]), valid: 1'b1, ost: 12'h000};
    end
    for (int i = 12; i < 22; i++) begin
      tbl[i] = '{req: 4'hF, ack: 1'b0, done: 4'h0, id: 2'd1, valid: 1'b1, ost: 12'h000};
    end

    aresetn   = 1'b0;
    req       = 4'hF;
    ack       = 1'b0;
    done      = 4'h0;
    weight    = 16'h4321;
    ost_limit = 12'h000;

    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("reset_hold", 4'b0000, 2'd0, 1'b0, 12'h000);
    end
    aresetn = 1'b1;
    step();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b1, 12'h000);

    for (int i = 0; i < 22; i++) begin
      req  = tbl[i].req;
      ack  = tbl[i].ack;
      done = tbl[i].done;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].valid ? (4'b0001 << tbl[i].id) : 4'b0000,
              tbl[i].id, tbl[i].valid, tbl[i].ost);
    end

    // Outstanding limit of 2 on p0, release by done, simultaneous ack+done, done on an idle counter.
    aresetn   = 1'b0;
    weight    = 16'h4324;
    ost_limit = 12'h002;
    req       = 4'b0001;
    ack       = 1'b0;
    done      = 4'h0;
    step();
    aresetn = 1'b1;
    step();
    chk_out("lim_grant", 4'b0001, 2'd0, 1'b1, 12'h000);
    ack = 1'b1;
    step();
    chk_out("lim_ack1", 4'b0001, 2'd0, 1'b1, 12'h001);
    step();
    chk_out("lim_ack2", 4'b0000, 2'd0, 1'b0, 12'h002);
    ack = 1'b0;
    step();
    chk_out("lim_blocked", 4'b0000, 2'd0, 1'b0, 12'h002);
    done = 4'b0001;
    step();
    chk_out("lim_release", 4'b0001, 2'd0, 1'b1, 12'h001);
    ack = 1'b1;
    step();
    chk_out("ack_and_done", 4'b0001, 2'd0, 1'b1, 12'h001);
    ack  = 1'b0;
    done = 4'b0100;
    step();
    chk_out("done_on_zero", 4'b0001, 2'd0, 1'b1, 12'h001);

    done    = 4'h0;
    ack     = 1'b1;
    aresetn = 1'b0;
    step();
    chk_out("reset_mid_burst", 4'b0000, 2'd0, 1'b0, 12'h000);

    // Single requester p2 (weight 3), no limit: credit reloads on itself until the counter saturates.
    aresetn   = 1'b1;
    ost_limit = 12'h000;
    req       = 4'b0100;
    ack       = 1'b0;
    step();
    chk_out("solo_grant", 4'b0100, 2'd2, 1'b1, 12'h000);
    ack = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_out($sformatf("solo_ack%0d", k), (k < 7) ? 4'b0100 : 4'b0000, 2'd2,
              (k < 7) ? 1'b1 : 1'b0, 12'(k) << 6);
    end
    ack  = 1'b0;
    done = 4'b0100;
    step();
    chk_out("sat_release", 4'b0100, 2'd2, 1'b1, 12'h180);
    done = 4'h0;
    req  = 4'b0010;
    step();
    chk_out("req_drop_rearb", 4'b0010, 2'd1, 1'b1, 12'h180);

    // Heavy p0 (weight 15) against p1, ack every other cycle.
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    weight  = 16'h432F;
    req     = 4'b0011;
    done    = 4'hF;
    ack     = 1'b0;
    acks_p0 = 0;
    at_cyc  = -1;
    seen    = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      ack = c[0];
      if (ack && gnt_valid && gnt_id == 2'd0) acks_p0++;
      step();
      if (gnt_valid && gnt_id == 2'd1) begin
        seen   = 1'b1;
        at_cyc = c + 1;
      end
    end
    chk("p1_grant_seen", 32'(seen), 32'd1);
`ifdef AXI_WRR_ARB_STARVE_EN
    chk("p1_starve_latency_ok", 32'((at_cyc > 0) && (at_cyc <= 10)), 32'd1);
`else
    chk("p0_acks_before_p1", 32'(acks_p0), 32'd15);
    chk("p1_grant_cycle", 32'(at_cyc), 32'd30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
